// File: rtl/person_counter_pkg.sv
// Shared constants for the doorway occupancy counter.
// Holds the default count width, the FSM state encodings (`PC_ST_*) and the
// state type used by person_counter and anyone observing its debug state.
`ifndef PERSON_COUNTER_DATA_WIDTH
`define PERSON_COUNTER_DATA_WIDTH 8
`endif

`define PC_ST_IDLE     3'd0
`define PC_ST_IN_A     3'd1
`define PC_ST_IN_AB    3'd2
`define PC_ST_IN_B     3'd3
`define PC_ST_OUT_B    3'd4
`define PC_ST_OUT_BA   3'd5
`define PC_ST_OUT_A    3'd6
`define PC_ST_WAIT_CLR 3'd7

package person_counter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = `PC_ST_IDLE,
        ST_IN_A     = `PC_ST_IN_A,
        ST_IN_AB    = `PC_ST_IN_AB,
        ST_IN_B     = `PC_ST_IN_B,
        ST_OUT_B    = `PC_ST_OUT_B,
        ST_OUT_BA   = `PC_ST_OUT_BA,
        ST_OUT_A    = `PC_ST_OUT_A,
        ST_WAIT_CLR = `PC_ST_WAIT_CLR
    } pc_state_e;

    // True while a passage is in progress (the states that may time out).
    function automatic logic is_passage_state(input pc_state_e s);
        return (s != ST_IDLE) && (s != ST_WAIT_CLR);
    endfunction

endpackage

// File: rtl/person_counter_sensor_debouncer.sv
// Beam-sensor conditioner: 2-FF synchronizer followed by a stability filter.
// The debounced level only flips after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; any return to the current
// level restarts the count.
module sensor_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    // Bring the asynchronous beam signal into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], async_i};
        end
    end

    // Accept a new level only after it has been stable long enough.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync[1] == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign level_o = r_level;

endmodule

// File: rtl/person_counter.sv
// Doorway occupancy counter: decodes passages across two IR beams (A outside,
// B inside) and keeps a saturating person count for security_controller.
// Optional feature macro: PERSON_COUNTER_TIMEOUT_EN adds a dwell timeout that
// abandons a passage stuck in one state for TIMEOUT_CYCLES cycles.
module person_counter
    import person_counter_pkg::*;
#(
    parameter int unsigned COUNT_W         = `PERSON_COUNTER_DATA_WIDTH,
    parameter int unsigned MAX_COUNT       = (1 << COUNT_W) - 1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned TIMEOUT_CYCLES  = 5000000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               sensor_a_i,
    input  logic               sensor_b_i,
    input  logic               count_clr_i,
    output logic [COUNT_W-1:0] person_count_o,
    output logic               entry_pulse_o,
    output logic               exit_pulse_o,
    output logic               sat_o,
    output logic               seq_err_o,
    output logic               timeout_o,
    output pc_state_e          state_o
);

    localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

    logic               w_da;
    logic               w_db;
    logic [1:0]         w_in;
    pc_state_e          w_next_seq;
    pc_state_e          w_next;
    logic               w_entry;
    logic               w_exit;
    logic               w_err;

    pc_state_e          r_state;
    logic [COUNT_W-1:0] r_count;
    logic               r_entry;
    logic               r_exit;
    logic               r_sat;
    logic               r_err;

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (sensor_a_i),
        .level_o (w_da)
    );

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (sensor_b_i),
        .level_o (w_db)
    );

    assign w_in = {w_da, w_db};

    // Passage sequence decode: next state plus entry/exit/error events.
    always_comb begin
        w_next_seq = r_state;
        w_entry    = 1'b0;
        w_exit     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            ST_IDLE: case (w_in)
                2'b10:   w_next_seq = ST_IN_A;
                2'b01:   w_next_seq = ST_OUT_B;
                2'b11:   begin w_next_seq = ST_WAIT_CLR; w_err = 1'b1; end
                default: ;
            endcase
            ST_IN_A: case (w_in)
                2'b11:   w_next_seq = ST_IN_AB;
                2'b00:   w_next_seq = ST_IDLE;
                2'b01:   begin w_next_seq = ST_WAIT_CLR; w_err = 1'b1; end
                default: ;
            endcase
            ST_IN_AB: case (w_in)
                2'b01:   w_next_seq = ST_IN_B;
                2'b10:   w_next_seq = ST_IN_A;
                2'b00:   begin w_next_seq = ST_IDLE; w_err = 1'b1; end
                default: ;
            endcase
            ST_IN_B: case (w_in)
                2'b00:   begin w_next_seq = ST_IDLE; w_entry = 1'b1; end
                2'b11:   w_next_seq = ST_IN_AB;
                2'b10:   begin w_next_seq = ST_WAIT_CLR; w_err = 1'b1; end
                default: ;
            endcase
            ST_OUT_B: case (w_in)
                2'b11:   w_next_seq = ST_OUT_BA;
                2'b00:   w_next_seq = ST_IDLE;
                2'b10:   begin w_next_seq = ST_WAIT_CLR; w_err = 1'b1; end
                default: ;
            endcase
            ST_OUT_BA: case (w_in)
                2'b10:   w_next_seq = ST_OUT_A;
                2'b01:   w_next_seq = ST_OUT_B;
                2'b00:   begin w_next_seq = ST_IDLE; w_err = 1'b1; end
                default: ;
            endcase
            ST_OUT_A: case (w_in)
                2'b00:   begin w_next_seq = ST_IDLE; w_exit = 1'b1; end
                2'b11:   w_next_seq = ST_OUT_BA;
                2'b01:   begin w_next_seq = ST_WAIT_CLR; w_err = 1'b1; end
                default: ;
            endcase
            ST_WAIT_CLR: if (w_in == 2'b00) w_next_seq = ST_IDLE;
            default: w_next_seq = ST_IDLE;
        endcase
    end

`ifdef PERSON_COUNTER_TIMEOUT_EN
    localparam int unsigned DWELL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [DWELL_W-1:0] r_dwell;
    logic               r_timeout;
    logic               w_timeout;

    // A real transition in the same cycle takes precedence over the timeout.
    assign w_timeout = is_passage_state(r_state) && (w_next_seq == r_state) &&
                       (r_dwell == DWELL_W'(TIMEOUT_CYCLES - 1));
    assign w_next    = w_timeout ? ST_WAIT_CLR : w_next_seq;

    // Dwell counter: cycles spent in the current passage state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dwell   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (!is_passage_state(r_state) || (w_next != r_state)) begin
                r_dwell <= '0;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_next    = w_next_seq;
    assign timeout_o = 1'b0;
`endif

    // State register, event pulses and the saturating count, updated together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_entry <= 1'b0;
            r_exit  <= 1'b0;
            r_sat   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_entry <= w_entry;
            r_exit  <= w_exit;
            r_err   <= w_err;
            r_sat   <= 1'b0;
            if (count_clr_i) begin
                r_count <= '0;
            end else if (w_entry) begin
                if (r_count == MAX_C) r_sat <= 1'b1;
                else                  r_count <= r_count + 1'b1;
            end else if (w_exit) begin
                if (r_count == '0) r_sat <= 1'b1;
                else               r_count <= r_count - 1'b1;
            end
        end
    end

    assign person_count_o = r_count;
    assign entry_pulse_o  = r_entry;
    assign exit_pulse_o   = r_exit;
    assign sat_o          = r_sat;
    assign seq_err_o      = r_err;
    assign state_o        = r_state;

endmodule

// File: tb/tb_person_counter.sv
// Bench for person_counter: directed scenarios followed by random passages,
// each judged against a passage-level model of the occupancy count.
module tb_person_counter;
    import person_counter_pkg::*;

    localparam int unsigned COUNT_W = 4;
    localparam int unsigned MAX_CNT = 15;

    logic               clk;
    logic               rst_ni;
    logic               sensor_a;
    logic               sensor_b;
    logic               count_clr;
    logic [COUNT_W-1:0] person_count;
    logic               entry_pulse;
    logic               exit_pulse;
    logic               sat;
    logic               seq_err;
    logic               timeout;
    pc_state_e          state;

    int n_checks = 0;
    int n_errors = 0;

    // pulse tallies gathered by the monitor
    int n_entry = 0;
    int n_exit  = 0;
    int n_sat   = 0;
    int n_err   = 0;
    int n_to    = 0;
    int cnt_at_pulse = -1;
    bit nonidle_seen = 0;

    int m_count = 0;

    person_counter #(
        .COUNT_W         (COUNT_W),
        .MAX_COUNT       (MAX_CNT),
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (100)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .sensor_a_i     (sensor_a),
        .sensor_b_i     (sensor_b),
        .count_clr_i    (count_clr),
        .person_count_o (person_count),
        .entry_pulse_o  (entry_pulse),
        .exit_pulse_o   (exit_pulse),
        .sat_o          (sat),
        .seq_err_o      (seq_err),
        .timeout_o      (timeout),
        .state_o        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_ni) begin
            if (entry_pulse) n_entry++;
            if (exit_pulse)  n_exit++;
            if (sat)         n_sat++;
            if (seq_err)     n_err++;
            if (timeout)     n_to++;
            if (entry_pulse || exit_pulse) cnt_at_pulse = int'(person_count);
            if (state != ST_IDLE) nonidle_seen = 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] ab, input int cycles);
        @(negedge clk);
        sensor_a = ab[1];
        sensor_b = ab[0];
        repeat (cycles - 1) @(negedge clk);
    endtask

    // Passage kinds: 0 entry, 1 exit, 2 back-out inside, 3 back-out outside,
    // 4 both beams at once, 5 abandon from AB, 6 entry with a wobble.
    task automatic run_pass(input int kind, input bit clr, input string tag);
        logic [1:0] lv[$];
        int e0, x0, s0, r0, t0;
        int exp_e, exp_x, exp_s, exp_r;
        lv = {};
        exp_e = 0; exp_x = 0; exp_s = 0; exp_r = 0;
        case (kind)
            0: lv = {2'b10, 2'b11, 2'b01, 2'b00};
            1: lv = {2'b01, 2'b11, 2'b10, 2'b00};
            2: lv = {2'b10, 2'b00};
            3: lv = {2'b01, 2'b00};
            4: lv = {2'b11, 2'b00};
            5: lv = {2'b10, 2'b11, 2'b00};
            default: lv = {2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00};
        endcase
        e0 = n_entry; x0 = n_exit; s0 = n_sat; r0 = n_err; t0 = n_to;
        cnt_at_pulse = -1;
        foreach (lv[i]) begin
            if (i == lv.size() - 1) count_clr = clr;
            step(lv[i], 10);
        end
        count_clr = 1'b0;
        if (kind == 0 || kind == 6) begin
            exp_e = 1;
            if (clr) m_count = 0;
            else if (m_count == MAX_CNT) exp_s = 1;
            else m_count = m_count + 1;
        end else if (kind == 1) begin
            exp_x = 1;
            if (clr) m_count = 0;
            else if (m_count == 0) exp_s = 1;
            else m_count = m_count - 1;
        end else begin
            if (clr) m_count = 0;
            if (kind == 4 || kind == 5) exp_r = 1;
        end
        chk({tag, " count"},   person_count, m_count);
        chk({tag, " entry"},   n_entry - e0, exp_e);
        chk({tag, " exit"},    n_exit - x0, exp_x);
        chk({tag, " sat"},     n_sat - s0, exp_s);
        chk({tag, " seq_err"}, n_err - r0, exp_r);
        chk({tag, " timeout"}, n_to - t0, 0);
        chk({tag, " state"},   state, ST_IDLE);
        if (exp_e + exp_x > 0) chk({tag, " count at pulse"}, cnt_at_pulse, m_count);
    endtask

    initial begin
        int e0, x0, s0, r0, t0, kind;
        bit clr;
        rst_ni    = 1'b0;
        sensor_a  = 1'b0;
        sensor_b  = 1'b0;
        count_clr = 1'b0;
        #1;
        chk("reset count", person_count, 0);
        chk("reset state", state, ST_IDLE);
        chk("reset pulses", {entry_pulse, exit_pulse, sat, seq_err, timeout}, 0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;

        // single entry, then count to 3, an exit and a back-out
        run_pass(0, 0, "entry1");
        run_pass(0, 0, "entry2");
        run_pass(0, 0, "entry3");
        run_pass(1, 0, "exit1");
        run_pass(2, 0, "backout");

        // glitches shorter than the debounce window are invisible
        e0 = n_entry; r0 = n_err; nonidle_seen = 0;
        repeat (3) begin
            step(2'b10, 2);
            step(2'b00, 3);
        end
        repeat (10) @(negedge clk);
        chk("glitch no state change", nonidle_seen, 0);
        chk("glitch no pulses", (n_entry - e0) + (n_err - r0), 0);

        // both beams at once from IDLE
        r0 = n_err;
        step(2'b11, 10);
        chk("simul state", state, ST_WAIT_CLR);
        chk("simul err", n_err - r0, 1);
        step(2'b00, 10);
        chk("simul back idle", state, ST_IDLE);
        run_pass(5, 0, "abandon_ab");

        // saturation at the top
        run_pass(2, 1, "clear");
        for (int i = 0; i < 16; i++) run_pass(0, 0, $sformatf("fill%0d", i));
        chk("full count", person_count, MAX_CNT);

        // exit at zero
        run_pass(2, 1, "clear2");
        run_pass(1, 0, "exit_at_zero");

        // clear wins over a completing entry
        for (int i = 0; i < 7; i++) run_pass(0, 0, $sformatf("to7_%0d", i));
        chk("count seven", person_count, 7);
        run_pass(0, 1, "clr_on_entry");

        // reset in the middle of a passage
        run_pass(0, 0, "pre_rst1");
        run_pass(0, 0, "pre_rst2");
        step(2'b10, 10);
        step(2'b11, 10);
        chk("rst mid state", state, ST_IN_AB);
        #1 rst_ni = 1'b0;
        #1;
        m_count = 0;
        chk("rst async count", person_count, 0);
        chk("rst async state", state, ST_IDLE);
        chk("rst async pulses", {entry_pulse, exit_pulse, sat, seq_err, timeout}, 0);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        e0 = n_entry; x0 = n_exit; r0 = n_err;
        repeat (20) @(negedge clk);
        chk("post rst pulses", (n_entry - e0) + (n_exit - x0) + (n_err - r0), 0);
        chk("post rst count", person_count, 0);

        // dwell timeout
        run_pass(0, 0, "pre_to");
        t0 = n_to; e0 = n_entry; s0 = n_sat;
        step(2'b10, 120);
`ifdef PERSON_COUNTER_TIMEOUT_EN
        chk("timeout pulses", n_to - t0, 1);
        chk("timeout state", state, ST_WAIT_CLR);
`else
        chk("timeout pulses", n_to - t0, 0);
        chk("timeout state", state, ST_IN_A);
`endif
        step(2'b00, 10);
        chk("timeout idle", state, ST_IDLE);
        chk("timeout count", person_count, m_count);
        chk("timeout no entry", (n_entry - e0) + (n_sat - s0), 0);

        // random passages
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 6);
            clr  = ($urandom_range(0, 7) == 0);
            run_pass(kind, clr, $sformatf("rnd%0d_k%0d", i, kind));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
